rx_frame_parser: RTL and testbench
==================================

Name: rx_frame_parser

Overview:
- Sits between the RGMII receive byte stream and the majority/decoding stage, on the same receive clock.
- Strips preamble/SFD and checks the Ethernet FCS (CRC-32) plus frame length.
- Captures the 16-bit frame ID at a fixed body offset and forwards body bytes with the 4 FCS bytes removed.
- Issues a per-frame done/ok/bad verdict and keeps good/bad frame counters for LEDs and the logger.

Parameters:
- ID_OFFSET, 25: body byte index of the frame-ID MSB. Index 0 is the first byte after SFD (dest MAC byte 0); the LSB is at ID_OFFSET+1.
- MIN_LEN, 64: minimum body length including FCS, in bytes.
- MAX_LEN, 1518: maximum body length including FCS, in bytes.

Ports:
- rx_clk  in  1  receive byte clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_enable  in  1  byte valid. Held high for the whole frame; any low cycle ends the frame.
- rx_error  in  1  PHY error flag, qualified by rx_enable.
- out_data  out  8  forwarded body byte; FCS is never forwarded.
- out_valid  out  1  out_data valid for one cycle.
- out_sof  out  1  high with out_valid on body byte 0.
- frame_done  out  1  one-cycle pulse when the frame verdict is available.
- frame_ok  out  1  valid with frame_done: frame passed all checks.
- frame_id  out  16  ID of the last frame with frame_done and frame_ok; held between frames.
- good_count  out  32  frames ended with frame_ok=1; wraps.
- bad_count  out  32  frames ended with frame_ok=0; wraps.

Behaviour:
- Reset (async assert, sync release) clears every output, counter, the delay line and the CRC, and sets state = SYNC.
- SYNC: wait for rx_enable=0, then go to IDLE. A frame cut by reset produces no output and no verdict.
- IDLE, rx_enable=1:
  - 0x55 -> PRE.
  - 0xD5 -> BODY (a missing preamble is tolerated).
  - Any other byte -> DROP.
- PRE, rx_enable=1:
  - 0x55 -> stay in PRE.
  - 0xD5 -> BODY.
  - Other byte -> DROP.
- PRE, rx_enable=0: -> IDLE with no verdict (preamble only, not counted).
- On entry to BODY:
  - CRC register = 0xFFFFFFFF.
  - byte_idx = 0 (11-bit, saturates at 2047).
  - len_err = 0.
- BODY, each rx_enable=1 cycle:
  - CRC-32 (poly 0x04C11DB7, reflected, LSB-first) is updated with rx_data.
  - Byte pushed into the 4-deep delay line; byte_idx increments.
  - rx_error=1 -> go to DROP.
- Forwarding:
  - Once the delay line holds 4 bytes, each further push emits the oldest byte registered: out_valid=1 on the cycle after the push.
  - A body byte therefore appears on out_data one cycle after body byte idx+4 is received.
  - The last 4 body bytes (FCS) remain in the line and are discarded.
- ID capture: when body byte ID_OFFSET / ID_OFFSET+1 is received, it goes into a pending ID register. frame_id is updated from that register only when the frame ends ok.
- BODY, rx_enable=0 -> EVAL, a single cycle:
  - frame_ok = 1 iff CRC residue == 0xDEBB20E3 (bit-reversed/complemented form of magic 0xC704DD7B).
  - AND MIN_LEN <= byte_idx <= MAX_LEN.
  - AND ID_OFFSET+1 < byte_idx.
  - Then frame_done=1, the matching counter increments, state -> IDLE.
  - frame_done is therefore 1 cycle after the first rx_enable=0 cycle.
- DROP: wait for rx_enable=0, then emit frame_done=1 with frame_ok=0, increment bad_count, go to IDLE. Bytes already forwarded stay forwarded; the consumer discards on frame_ok=0.
- Runt (<4 body bytes): nothing forwarded; verdict bad.
- Giant (byte_idx saturated or >MAX_LEN): forwarding continues; verdict bad.
- frame_done and a new frame's first byte can never collide: EVAL consumes the gap cycle.
- Counters wrap 0xFFFFFFFF -> 0.
- out_valid, out_sof, frame_done and frame_ok are 0 whenever not explicitly asserted.

Test Plan:
- Good frame (7x 0x55, 0xD5, 60 body bytes, correct FCS):
  - 60 out_valid pulses; out_sof on the first.
  - frame_done with frame_ok=1 one cycle after rx_enable falls.
  - good_count=1.
- Same frame, one payload bit flipped -> 60 bytes still forwarded, frame_ok=0, bad_count=1, frame_id unchanged.
- Body bytes 25,26 = 0x12,0x34 in a good frame -> frame_id=0x1234. A following bad frame with 0xAB,0xCD -> frame_id stays 0x1234.
- rx_error=1 at body byte 30 -> DROP, no further out_valid, frame_done/frame_ok=0 after rx_enable falls.
- Runt: SFD + 3 bytes -> no out_valid, bad verdict. Preamble-only burst -> no frame_done.
- resetn low for 2 cycles at body byte 20 while rx_enable stays high:
  - Outputs and counters are 0 immediately.
  - No out_valid or verdict until rx_enable falls.
  - The next good frame is accepted normally.

Source files
------------

// File: rtl/rx_frame_parser.sv
// Receive-side Ethernet frame parser: strips preamble/SFD, checks FCS and length,
// forwards body bytes minus FCS, captures a frame ID and counts good/bad frames.
module rx_frame_parser #(
   parameter int ID_OFFSET = 25,
   parameter int MIN_LEN   = 64,
   parameter int MAX_LEN   = 1518
) (
   input  logic        rx_clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_enable,
   input  logic        rx_error,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [15:0] frame_id,
   output logic [31:0] good_count,
   output logic [31:0] bad_count
);

   localparam logic [2:0]  ST_SYNC = 3'd0;
   localparam logic [2:0]  ST_IDLE = 3'd1;
   localparam logic [2:0]  ST_PRE  = 3'd2;
   localparam logic [2:0]  ST_BODY = 3'd3;
   localparam logic [2:0]  ST_EVAL = 3'd4;
   localparam logic [2:0]  ST_DROP = 3'd5;

   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [10:0] IDX_SAT     = 11'h7FF;
   localparam logic [10:0] MIN_IDX     = 11'(MIN_LEN);
   localparam logic [10:0] MAX_IDX     = 11'(MAX_LEN);
   localparam logic [10:0] ID_HI_IDX   = 11'(ID_OFFSET);
   localparam logic [10:0] ID_LO_IDX   = 11'(ID_OFFSET + 1);

   // Reflected CRC-32 (poly 0x04C11DB7), one byte LSB-first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) begin
            c = (c >> 1) ^ 32'hEDB8_8320;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   logic [1:0]       rst_sync_q;
   logic             rst_n_s;
   logic [2:0]       state_q, state_d;
   logic [31:0]      crc_q, crc_d;
   logic [10:0]      byte_idx_q, byte_idx_d;
   logic             len_err_q, len_err_d;
   logic [3:0][7:0]  dline_q, dline_d;
   logic [15:0]      id_pend_q, id_pend_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sof_q, out_sof_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_ok_q, frame_ok_d;
   logic [15:0]      frame_id_q, frame_id_d;
   logic [31:0]      good_q, good_d;
   logic [31:0]      bad_q, bad_d;
   logic             verdict_ok_s;

   // Reset asserts asynchronously but is released on the clock.
   always_ff @(posedge rx_clk or negedge resetn) begin
      if (!resetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_q[1];

   assign verdict_ok_s = (crc_q == CRC_RESIDUE) && !len_err_q &&
                         (byte_idx_q >= MIN_IDX) && (byte_idx_q <= MAX_IDX) &&
                         (byte_idx_q > ID_LO_IDX);

   // Frame state machine, delay line, verdict and counters.
   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      byte_idx_d   = byte_idx_q;
      len_err_d    = len_err_q;
      dline_d      = dline_q;
      id_pend_d    = id_pend_q;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      out_sof_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_ok_d   = 1'b0;
      frame_id_d   = frame_id_q;
      good_d       = good_q;
      bad_d        = bad_q;
      case (state_q)
         ST_SYNC: begin
            if (!rx_enable) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SYNC;
            end
         end
         // A preamble burst that ends without SFD falls back to IDLE silently.
         ST_IDLE, ST_PRE: begin
            if (!rx_enable) begin
               state_d = ST_IDLE;
            end else if (rx_data == SFD_BYTE) begin
               state_d    = ST_BODY;
               crc_d      = CRC_INIT;
               byte_idx_d = 11'd0;
               len_err_d  = 1'b0;
            end else if (rx_data == PRE_BYTE) begin
               state_d = ST_PRE;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_BODY: begin
            if (!rx_enable) begin
               state_d      = ST_EVAL;
               frame_done_d = 1'b1;
               frame_ok_d   = verdict_ok_s;
               if (verdict_ok_s) begin
                  good_d     = good_q + 32'd1;
                  frame_id_d = id_pend_q;
               end else begin
                  bad_d = bad_q + 32'd1;
               end
            end else if (rx_error) begin
               state_d = ST_DROP;
            end else begin
               crc_d      = crc32_byte(crc_q, rx_data);
               dline_d    = {dline_q[2:0], rx_data};
               byte_idx_d = (byte_idx_q == IDX_SAT) ? IDX_SAT : byte_idx_q + 11'd1;
               len_err_d  = len_err_q | (byte_idx_q >= MAX_IDX);
               // Line full: the oldest byte leaves as this one enters, so FCS never escapes.
               if (byte_idx_q >= 11'd4) begin
                  out_valid_d = 1'b1;
                  out_data_d  = dline_q[3];
                  out_sof_d   = (byte_idx_q == 11'd4);
               end else begin
                  out_data_d  = out_data_q;
               end
               if (byte_idx_q == ID_HI_IDX) begin
                  id_pend_d[15:8] = rx_data;
               end else if (byte_idx_q == ID_LO_IDX) begin
                  id_pend_d[7:0] = rx_data;
               end else begin
                  id_pend_d = id_pend_q;
               end
            end
         end
         ST_EVAL: begin
            state_d = ST_IDLE;
         end
         ST_DROP: begin
            if (!rx_enable) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
               bad_d        = bad_q + 32'd1;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge rx_clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q      <= ST_SYNC;
         crc_q        <= 32'd0;
         byte_idx_q   <= 11'd0;
         len_err_q    <= 1'b0;
         dline_q      <= 32'd0;
         id_pend_q    <= 16'd0;
         out_data_q   <= 8'd0;
         out_valid_q  <= 1'b0;
         out_sof_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         frame_id_q   <= 16'd0;
         good_q       <= 32'd0;
         bad_q        <= 32'd0;
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         byte_idx_q   <= byte_idx_d;
         len_err_q    <= len_err_d;
         dline_q      <= dline_d;
         id_pend_q    <= id_pend_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_sof_q    <= out_sof_d;
         frame_done_q <= frame_done_d;
         frame_ok_q   <= frame_ok_d;
         frame_id_q   <= frame_id_d;
         good_q       <= good_d;
         bad_q        <= bad_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_sof    = out_sof_q;
   assign frame_done = frame_done_q;
   assign frame_ok   = frame_ok_q;
   assign frame_id   = frame_id_q;
   assign good_count = good_q;
   assign bad_count  = bad_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: directed frames with reference FCS,
// expected bytes/verdicts queued at stimulus time and checked by a monitor.
module tb_rx_frame_parser;

   logic        rx_clk = 1'b0;
   logic        resetn = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_enable = 1'b0;
   logic        rx_error = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid, out_sof, frame_done, frame_ok;
   logic [15:0] frame_id;
   logic [31:0] good_count, bad_count;

   always #5 rx_clk = ~rx_clk;

   rx_frame_parser dut (
      .rx_clk(rx_clk), .resetn(resetn), .rx_data(rx_data), .rx_enable(rx_enable),
      .rx_error(rx_error), .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
      .frame_done(frame_done), .frame_ok(frame_ok), .frame_id(frame_id),
      .good_count(good_count), .bad_count(bad_count)
   );

   typedef struct packed {
      logic        ok;
      logic [15:0] id;
      logic [31:0] good;
      logic [31:0] bad;
      logic [31:0] cyc;
   } verdict_t;

   logic [8:0]  exp_bytes[$];
   verdict_t    exp_verdicts[$];
   logic [7:0]  tx_q[$];
   logic [15:0] tx_id = 16'd0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] cyc = 32'd0;
   logic [31:0] m_good = 32'd0;
   logic [31:0] m_bad = 32'd0;
   logic [15:0] m_id = 16'd0;

   always @(posedge rx_clk) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s: got 0x%0h with nothing expected", name, act);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a byte or a verdict.
   always @(negedge rx_clk) begin : monitor
      logic [8:0] e;
      verdict_t   v;
      if (out_valid) begin
         if (exp_bytes.size() == 0) begin
            unexpected("unexpected_out_valid", {24'd0, out_data});
         end else begin
            e = exp_bytes.pop_front();
            check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
            check("out_sof", {31'd0, out_sof}, {31'd0, e[8]});
         end
      end else if (out_sof) begin
         unexpected("out_sof_without_valid", 32'd1);
      end
      if (frame_done) begin
         if (exp_verdicts.size() == 0) begin
            unexpected("unexpected_frame_done", {31'd0, frame_ok});
         end else begin
            v = exp_verdicts.pop_front();
            check("frame_ok", {31'd0, frame_ok}, {31'd0, v.ok});
            check("frame_id", {16'd0, frame_id}, {16'd0, v.id});
            check("good_count", good_count, v.good);
            check("bad_count", bad_count, v.bad);
            check("done_cycle", cyc, v.cyc);
         end
      end else if (frame_ok) begin
         unexpected("frame_ok_without_done", 32'd1);
      end
   end

   function automatic logic [31:0] ref_crc();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (tx_q[k]) begin
         c = c ^ {24'd0, tx_q[k]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   task automatic build_frame(input int n_data, input logic [15:0] id);
      logic [31:0] fcs;
      tx_q.delete();
      for (int j = 0; j < n_data; j++) tx_q.push_back(8'(j * 7 + 3) ^ 8'hA5);
      if (n_data > 26) begin
         tx_q[25] = id[15:8];
         tx_q[26] = id[7:0];
      end
      tx_id = id;
      fcs = ref_crc();
      for (int k = 0; k < 4; k++) tx_q.push_back(fcs[8*k +: 8]);
   endtask

   task automatic drive(input logic en, input logic [7:0] d, input logic err);
      @(posedge rx_clk);
      #1;
      rx_enable = en;
      rx_data   = d;
      rx_error  = err;
   endtask

   // err_at / rst_at < 0 disable the error injection / mid-frame reset.
   task automatic send_frame(input int n_pre, input bit sfd, input int err_at,
                             input int rst_at, input bit exp_ok);
      verdict_t v;
      for (int i = 0; i < n_pre; i++) drive(1'b1, 8'h55, 1'b0);
      if (sfd) drive(1'b1, 8'hD5, 1'b0);
      for (int j = 0; j < tx_q.size(); j++) begin
         drive(1'b1, tx_q[j], (j == err_at));
         // Byte j-4 emerges after byte j; a reset one cycle later swallows that pulse.
         if (sfd && j >= 4 && (err_at < 0 || j < err_at) && (rst_at < 0 || j < rst_at - 1))
            exp_bytes.push_back({(j == 4), tx_q[j-4]});
         if (j == rst_at) begin
            resetn = 1'b0;
            #1;
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_data", {24'd0, out_data}, 32'd0);
            check("rst_frame_done", {31'd0, frame_done}, 32'd0);
            check("rst_frame_id", {16'd0, frame_id}, 32'd0);
            check("rst_good_count", good_count, 32'd0);
            check("rst_bad_count", bad_count, 32'd0);
            m_good = 32'd0;
            m_bad  = 32'd0;
            m_id   = 16'd0;
         end
         if (rst_at >= 0 && j == rst_at + 2) resetn = 1'b1;
      end
      drive(1'b0, 8'h00, 1'b0);
      if (rst_at < 0) begin
         if (exp_ok) begin
            m_good = m_good + 32'd1;
            m_id   = tx_id;
         end else begin
            m_bad = m_bad + 32'd1;
         end
         v.ok = exp_ok; v.id = m_id; v.good = m_good; v.bad = m_bad; v.cyc = cyc + 32'd1;
         exp_verdicts.push_back(v);
      end
      repeat (3) drive(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 resetn = 1'b0;
      repeat (4) @(posedge rx_clk);
      #1 resetn = 1'b1;
      repeat (5) drive(1'b0, 8'h00, 1'b0);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_sof", {31'd0, out_sof}, 32'd0);
      check("reset_out_data", {24'd0, out_data}, 32'd0);
      check("reset_frame_done", {31'd0, frame_done}, 32'd0);
      check("reset_frame_ok", {31'd0, frame_ok}, 32'd0);
      check("reset_frame_id", {16'd0, frame_id}, 32'd0);
      check("reset_good_count", good_count, 32'd0);
      check("reset_bad_count", bad_count, 32'd0);

      build_frame(60, 16'h1234);            send_frame(7, 1'b1, -1, -1, 1'b1);
      build_frame(60, 16'h1234); tx_q[40] ^= 8'h10; send_frame(7, 1'b1, -1, -1, 1'b0);
      build_frame(60, 16'hABCD); tx_q[45] ^= 8'h01; send_frame(7, 1'b1, -1, -1, 1'b0);
      build_frame(60, 16'h2222);            send_frame(7, 1'b1, 30, -1, 1'b0);
      tx_q = '{8'h01, 8'h02, 8'h03};        send_frame(7, 1'b1, -1, -1, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
      repeat (4) drive(1'b0, 8'h00, 1'b0);
      build_frame(59, 16'h3333);            send_frame(7, 1'b1, -1, -1, 1'b0);
      build_frame(60, 16'h5678);            send_frame(0, 1'b1, -1, -1, 1'b1);
      tx_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66}; send_frame(0, 1'b0, -1, -1, 1'b0);
      build_frame(1514, 16'h4444);          send_frame(7, 1'b1, -1, -1, 1'b1);
      build_frame(1515, 16'h5555);          send_frame(7, 1'b1, -1, -1, 1'b0);
      build_frame(60, 16'h6666);            send_frame(7, 1'b1, -1, 20, 1'b1);
      build_frame(60, 16'h7777);            send_frame(7, 1'b1, -1, -1, 1'b1);

      repeat (20) @(posedge rx_clk);
      check("bytes_drained", exp_bytes.size(), 32'd0);
      check("verdicts_drained", exp_verdicts.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
